// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle CPU controller: state enum,
// opcode/op constants, register and write-back select codes, and the
// per-state control-word decode.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_NONE  = 3'b000;
    localparam logic [2:0] NSEL_RN    = 3'b100;
    localparam logic [2:0] NSEL_RD    = 3'b010;
    localparam logic [2:0] NSEL_RM    = 3'b001;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       write;
        logic       err;
    } ctrl_t;

    // Control word presented while the machine sits in state st for the
    // instruction whose latched fields are opc/op.
    function automatic ctrl_t decode_ctrl(input state_t st,
                                          input logic [2:0] opc,
                                          input logic [1:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_WAIT:   c.w = 1'b1;
            S_DECODE: c.w = 1'b0;
            S_GET_A: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_GET_B: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_EXEC: begin
                c.asel = (opc == OPC_MOV) ? 1'b1 : 1'b0;
                if ((opc == OPC_ALU) && (op == OP_CMP)) begin
                    c.loads = 1'b1;
                end else begin
                    c.loadc = 1'b1;
                end
            end
            S_WR_REG: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            S_WR_IMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_IMM8;
                c.write = 1'b1;
            end
            S_ERROR:  c.err = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Decoder/datapath bundle for the CPU controller. The master side
// issues start and the instruction fields; the slave (the controller)
// returns the wait flag and every datapath control.
interface cpu_ctrl_fsm_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
    logic       err;

    modport master (
        output s, opcode, op,
        input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err
    );

    modport slave (
        input  s, opcode, op,
        output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for the 16-bit CPU. Sequences each instruction
// through read / execute / write-back and drives the datapath controls.
// Outputs are registered from the next state, so they depend only on
// state and never combinationally on inputs.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal instructions enter a
// sticky ERROR state (err = 1) instead of returning to WAIT.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    cpu_ctrl_fsm_if.slave     bus
);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_opcode;
    logic [1:0] r_op;
    ctrl_t      r_ctrl;
    ctrl_t      w_ctrl_next;

    // Next-state selection from the current state and the latched instruction.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT: begin
                if (bus.s) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_DECODE: begin
                if ((r_opcode == OPC_MOV) && (r_op == OP_MOV_IMM)) begin
                    w_next_state = S_WR_IMM;
                end else if ((r_opcode == OPC_MOV) && (r_op == OP_MOV_REG)) begin
                    w_next_state = S_GET_B;
                end else if ((r_opcode == OPC_ALU) && (r_op == OP_MVN)) begin
                    w_next_state = S_GET_B;
                end else if (r_opcode == OPC_ALU) begin
                    w_next_state = S_GET_A;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    w_next_state = S_ERROR;
`else
                    w_next_state = S_WAIT;
`endif
                end
            end
            S_GET_A:  w_next_state = S_GET_B;
            S_GET_B:  w_next_state = S_EXEC;
            S_EXEC: begin
                if ((r_opcode == OPC_ALU) && (r_op == OP_CMP)) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_WR_REG;
                end
            end
            S_WR_REG: w_next_state = S_WAIT;
            S_WR_IMM: w_next_state = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ERROR:  w_next_state = S_ERROR;
`endif
            default:  w_next_state = S_WAIT;
        endcase
    end

    // Control word for the state about to be entered; DECODE carries no
    // controls, so the already-latched instruction fields are sufficient.
    always_comb begin
        w_ctrl_next = decode_ctrl(w_next_state, r_opcode, r_op);
`ifndef CTRL_ILLEGAL_TRAP_EN
        w_ctrl_next.err = 1'b0;
`endif
    end

    // State, instruction latch and registered outputs; reset aborts any
    // instruction in flight and returns to WAIT with only w asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_WAIT;
            r_opcode <= 3'b000;
            r_op     <= 2'b00;
            r_ctrl   <= decode_ctrl(S_WAIT, 3'b000, 2'b00);
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= w_ctrl_next;
            if ((r_state == S_WAIT) && bus.s) begin
                r_opcode <= bus.opcode;
                r_op     <= bus.op;
            end
        end
    end

    assign bus.w     = r_ctrl.w;
    assign bus.nsel  = r_ctrl.nsel;
    assign bus.loada = r_ctrl.loada;
    assign bus.loadb = r_ctrl.loadb;
    assign bus.loadc = r_ctrl.loadc;
    assign bus.loads = r_ctrl.loads;
    assign bus.asel  = r_ctrl.asel;
    assign bus.bsel  = r_ctrl.bsel;
    assign bus.vsel  = r_ctrl.vsel;
    assign bus.write = r_ctrl.write;
    assign bus.err   = r_ctrl.err;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm. A reference model turns each
// instruction into the list of control words expected after each clock
// edge; directed cases cover reset, latching, back-to-back start and
// illegal opcodes, followed by a randomized instruction stream.
module tb_cpu_ctrl_fsm;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed control word: {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err}
    logic [13:0] obs;
    assign obs = {bus.w, bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
                  bus.asel, bus.bsel, bus.vsel, bus.write, bus.err};

    logic [13:0] exp_q[$];

    function automatic logic [13:0] cw(input logic w, input logic [2:0] nsel,
                                       input logic la, input logic lb,
                                       input logic lc, input logic ls,
                                       input logic as, input logic [1:0] vsel,
                                       input logic wr, input logic er);
        return {w, nsel, la, lb, lc, ls, as, 1'b0, vsel, wr, er};
    endfunction

    logic [13:0] IDLE, DEC, GETA, GETB, EXC_MOV, EXC_ALU, EXC_CMP, WRREG, WRIMM, ERRW;

    // Expected control words, one per edge after the edge that samples s.
    task automatic build_seq(input logic [2:0] opc, input logic [1:0] op);
        exp_q.delete();
        exp_q.push_back(DEC);
        if (opc == 3'b110 && op == 2'b10) begin
            exp_q.push_back(WRIMM);
        end else if (opc == 3'b110 && op == 2'b00) begin
            exp_q.push_back(GETB);
            exp_q.push_back(EXC_MOV);
            exp_q.push_back(WRREG);
        end else if (opc == 3'b101) begin
            if (op != 2'b11) exp_q.push_back(GETA);
            exp_q.push_back(GETB);
            if (op == 2'b01) begin
                exp_q.push_back(EXC_CMP);
            end else begin
                exp_q.push_back(EXC_ALU);
                exp_q.push_back(WRREG);
            end
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            exp_q.push_back(ERRW);
            return;
`endif
        end
        exp_q.push_back(IDLE);
    endtask

    task automatic chk(input string tag, input logic [13:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Issue one instruction; during the instruction the inputs are
    // scrambled (or set to alt fields) to prove s is ignored and fields are latched.
    task automatic run_instr(input string tag, input logic [2:0] opc, input logic [1:0] op,
                             input logic use_alt, input logic [2:0] alt_opc,
                             input logic [1:0] alt_op);
        build_seq(opc, op);
        bus.s      = 1'b1;
        bus.opcode = opc;
        bus.op     = op;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
            if (i == exp_q.size() - 1) begin
                bus.s = 1'b0;
            end else if (use_alt) begin
                bus.s      = 1'b0;
                bus.opcode = alt_opc;
                bus.op     = alt_op;
            end else begin
                bus.s      = 1'($urandom_range(1, 0));
                bus.opcode = 3'($urandom_range(7, 0));
                bus.op     = 2'($urandom_range(3, 0));
            end
        end
    endtask

    initial begin
        logic [2:0] ropc;
        logic [1:0] rop;
        clk = 1'b0;
        reset = 1'b1;
        tests_run = 0;
        tests_failed = 0;
        bus.s = 1'b0;
        bus.opcode = 3'b000;
        bus.op = 2'b00;

        IDLE    = cw(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        DEC     = cw(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        GETA    = cw(1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        GETB    = cw(1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        EXC_MOV = cw(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        EXC_ALU = cw(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        EXC_CMP = cw(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        WRREG   = cw(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        WRIMM   = cw(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        ERRW    = cw(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

        // Reset state
        @(negedge clk);
        chk("reset_state", IDLE);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_start", IDLE);

        // Directed legal instructions
        run_instr("mov_imm", 3'b110, 2'b10, 1'b1, 3'b000, 2'b00);
        run_instr("add",     3'b101, 2'b00, 1'b1, 3'b000, 2'b00);
        run_instr("cmp",     3'b101, 2'b01, 1'b1, 3'b000, 2'b00);
        run_instr("and",     3'b101, 2'b10, 1'b1, 3'b000, 2'b00);
        run_instr("mvn",     3'b101, 2'b11, 1'b1, 3'b000, 2'b00);
        run_instr("mov_reg", 3'b110, 2'b00, 1'b1, 3'b000, 2'b00);
        // ADD with the instruction register switched to MOV imm mid-flight
        run_instr("add_latch", 3'b101, 2'b00, 1'b1, 3'b110, 2'b10);

        // s held high: next instruction starts the edge after returning to WAIT
        bus.s = 1'b1; bus.opcode = 3'b110; bus.op = 2'b10;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); chk("b2b_dec", DEC);
            @(negedge clk); chk("b2b_wrimm", WRIMM);
            @(negedge clk); chk("b2b_wait", IDLE);
        end
        bus.s = 1'b0;
        @(negedge clk); chk("b2b_end", IDLE);

        // Reset asserted while in GET_B of an ADD
        bus.s = 1'b1; bus.opcode = 3'b101; bus.op = 2'b00;
        @(negedge clk); chk("rst_dec", DEC);
        bus.s = 1'b0;
        @(negedge clk); chk("rst_geta", GETA);
        @(negedge clk); chk("rst_getb", GETB);
        #2 reset = 1'b1;
        #1 chk("rst_async", IDLE);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("rst_after", IDLE);
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        // Illegal opcode traps; sticky through s pulses until reset
        run_instr("illegal", 3'b111, 2'b00, 1'b1, 3'b000, 2'b00);
        for (int k = 0; k < 10; k++) begin
            bus.s = 1'b1; bus.opcode = 3'b110; bus.op = 2'b10;
            @(negedge clk); chk("trap_sticky", ERRW);
            bus.s = 1'b0;
            @(negedge clk); chk("trap_sticky", ERRW);
        end
        #2 reset = 1'b1;
        #1 chk("trap_reset", IDLE);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); chk("trap_cleared", IDLE);
`else
        // Illegal opcodes fall straight back to WAIT
        run_instr("illegal111", 3'b111, 2'b00, 1'b1, 3'b000, 2'b00);
        run_instr("illegal110_11", 3'b110, 2'b11, 1'b1, 3'b000, 2'b00);
        run_instr("illegal000", 3'b000, 2'b01, 1'b1, 3'b000, 2'b00);
`endif

        // Randomized instruction stream with idle gaps
        for (int n = 0; n < 60; n++) begin
            ropc = 3'($urandom_range(7, 0));
            rop  = 2'($urandom_range(3, 0));
            if ($urandom_range(3, 0) != 0) begin
                ropc = ($urandom_range(1, 0) != 0) ? 3'b101 : 3'b110;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (!(ropc == 3'b101 || (ropc == 3'b110 && (rop == 2'b00 || rop == 2'b10)))) begin
                ropc = 3'b101;
            end
`endif
            run_instr("rand", ropc, rop, 1'b0, 3'b000, 2'b00);
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                @(negedge clk); chk("rand_gap", IDLE);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
